de2_70_ethernet_nios2_qsys_0_oci_dct_packer: RTL and testbench

DE2_70_ETHERNET_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: de2_70_ethernet_nios2_qsys_0_oci_dct_packer

---
 rtl/de2_70_ethernet_nios2_qsys_0_oci_dct_packer.sv | 190 +++++++++++++++++++
 tb/tb_de2_70_ethernet_nios2_qsys_0_oci_dct_packer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_ethernet_nios2_qsys_0_oci_dct_packer.sv
// Trace-code frame packer.
// Packs 2-bit trace codes into a 30-bit accumulator (up to 15 codes) and
// hands complete or flushed frames to a single-entry output register with a
// valid/ready handshake. A frame closes when it is full, on flush, or
// (optionally) after an idle timeout.
// Optional feature: define DCT_PACKER_TIMEOUT_EN to enable the idle-timeout
// auto-flush; without it frames close only when full or on flush.
module de2_70_ethernet_nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  input  logic        flush,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CODES = 4'd15;

  state_t      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic        frm_valid_q, frm_valid_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  buf_cnt_q, buf_cnt_d;
  logic        overflow_q, overflow_d;
  logic        flush_pend_q, flush_pend_d;
  logic        tmo_pend_q, tmo_pend_d;

  logic        slot_free;
  logic        full;
  logic        flush_req;
  logic        xfer_cond;
  logic        do_xfer;
  logic        code_accepted;
  logic        timeout;

`ifdef DCT_PACKER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(FLUSH_TIMEOUT);

  logic [7:0] idle_q, idle_d;

  // Idle counter: restarts on any accepted code or frame transfer, counts
  // while a partial frame sits in the accumulator, saturates at the limit.
  always_comb begin
    idle_d = idle_q;
    if (code_accepted || do_xfer) begin
      idle_d = 8'd0;
    end else if ((count_q != 4'd0) && (idle_q != TMO_LIMIT)) begin
      idle_d = idle_q + 8'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout = (idle_q == TMO_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      acc_q        <= 30'd0;
      count_q      <= 4'd0;
      frm_valid_q  <= 1'b0;
      buf_q        <= 30'd0;
      buf_cnt_q    <= 4'd0;
      overflow_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      tmo_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      frm_valid_q  <= frm_valid_d;
      buf_q        <= buf_d;
      buf_cnt_q    <= buf_cnt_d;
      overflow_q   <= overflow_d;
      flush_pend_q <= flush_pend_d;
      tmo_pend_q   <= tmo_pend_d;
    end
  end

  // Next-state logic: transfer decision, accumulator update, pending
  // flush/timeout retention and overflow detection.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    frm_valid_d   = frm_valid_q;
    buf_d         = buf_q;
    buf_cnt_d     = buf_cnt_q;
    overflow_d    = overflow_q;
    flush_pend_d  = flush_pend_q;
    tmo_pend_d    = tmo_pend_q;
    code_accepted = 1'b0;

    slot_free = !frm_valid_q || frm_ready;
    full      = (state_q == ST_FULL);
    // A flush only means something if there is (or is about to be) a code.
    flush_req = (flush || flush_pend_q) && ((count_q != 4'd0) || code_valid);
    xfer_cond = full || flush_req || timeout || tmo_pend_q;
    do_xfer   = xfer_cond && slot_free;

    if (do_xfer) begin
      frm_valid_d  = 1'b1;
      flush_pend_d = 1'b0;
      tmo_pend_d   = 1'b0;
      if (full) begin
        // Full frame leaves as-is; a code arriving now starts the next frame.
        buf_d     = acc_q;
        buf_cnt_d = MAX_CODES;
        if (code_valid) begin
          acc_d         = {28'd0, code};
          count_d       = 4'd1;
          code_accepted = 1'b1;
        end else begin
          acc_d   = 30'd0;
          count_d = 4'd0;
        end
      end else begin
        // Partial frame: a same-cycle code is folded into the closing frame.
        if (code_valid) begin
          buf_d         = {acc_q[27:0], code};
          buf_cnt_d     = count_q + 4'd1;
          code_accepted = 1'b1;
        end else begin
          buf_d     = acc_q;
          buf_cnt_d = count_q;
        end
        acc_d   = 30'd0;
        count_d = 4'd0;
      end
    end else begin
      if (frm_valid_q && frm_ready) begin
        frm_valid_d = 1'b0;
      end
      // Remember a close request that could not be served yet.
      if (flush_req) begin
        flush_pend_d = 1'b1;
      end
      if (timeout) begin
        tmo_pend_d = 1'b1;
      end
      if (code_valid) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          acc_d         = {acc_q[27:0], code};
          count_d       = count_q + 4'd1;
          code_accepted = 1'b1;
        end
      end
    end

    if (count_d == 4'd0) begin
      state_d = ST_EMPTY;
    end else if (count_d == MAX_CODES) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FILL;
    end
  end

  assign frm_valid  = frm_valid_q;
  assign dct_buffer = buf_q;
  assign dct_count  = buf_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_de2_70_ethernet_nios2_qsys_0_oci_dct_packer.sv
// Directed testbench for the trace-code frame packer.
module tb_de2_70_ethernet_nios2_qsys_0_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush;
  logic        frm_valid;
  logic        frm_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int n_checks;
  int n_fail;
  int seen;

  de2_70_ethernet_nios2_qsys_0_oci_dct_packer #(
    .FLUSH_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    code_valid = 1'b1;
    code       = c;
    step();
    code_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic v, input logic [29:0] b, input logic [3:0] n);
    check({tag, "_valid"}, {31'd0, frm_valid}, {31'd0, v});
    check({tag, "_buffer"}, {2'd0, dct_buffer}, {2'd0, b});
    check({tag, "_count"}, {28'd0, dct_count}, {28'd0, n});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    seen       = 0;
    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 2'b00;
    flush      = 1'b0;
    frm_ready  = 1'b1;

    // Reset state
    step();
    step();
    check_frame("reset", 1'b0, 30'd0, 4'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    step();

    // 15 codes of 01, consumer ready
    for (int i = 0; i < 15; i++) send(2'b01);
    check("full_not_yet", {31'd0, frm_valid}, 32'd0);
    step();
    check_frame("full15", 1'b1, 30'h15555555, 4'd15);
    step();
    check("full15_drop", {31'd0, frm_valid}, 32'd0);

    // Codes 11,10,01 then flush alone
    send(2'b11);
    send(2'b10);
    send(2'b01);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_frame("flush3", 1'b1, 30'h00000039, 4'd3);
    step();
    check("flush3_drop", {31'd0, frm_valid}, 32'd0);

    // Codes 11,10,01 then flush together with a 4th code 00
    send(2'b11);
    send(2'b10);
    send(2'b01);
    flush      = 1'b1;
    code_valid = 1'b1;
    code       = 2'b00;
    step();
    flush      = 1'b0;
    code_valid = 1'b0;
    check_frame("flush4", 1'b1, 30'h000000E4, 4'd4);
    step();

    // Flush in EMPTY with no code: nothing happens
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("empty_flush", {31'd0, frm_valid}, 32'd0);

    // 16th code arrives in the cycle of the FULL transfer
    for (int i = 0; i < 15; i++) send(2'b01);
    send(2'b11);
    check_frame("xfer16", 1'b1, 30'h15555555, 4'd15);
    check("xfer16_overflow", {31'd0, overflow}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_frame("xfer16_carry", 1'b1, 30'h00000003, 4'd1);
    step();
    check("xfer16_drop", {31'd0, frm_valid}, 32'd0);

    // Consumer stalled, 31 consecutive codes
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b01);
    for (int i = 0; i < 15; i++) send(2'b10);
    check_frame("stall_hold30", 1'b1, 30'h15555555, 4'd15);
    check("stall_no_ovf", {31'd0, overflow}, 32'd0);
    send(2'b11);
    check("stall_ovf", {31'd0, overflow}, 32'd1);
    step();
    step();
    check_frame("stall_hold_late", 1'b1, 30'h15555555, 4'd15);
    check("stall_ovf_sticky", {31'd0, overflow}, 32'd1);
    frm_ready = 1'b1;
    step();
    check_frame("stall_b2b", 1'b1, 30'h2AAAAAAA, 4'd15);
    step();
    check("stall_drop", {31'd0, frm_valid}, 32'd0);
    check("stall_ovf_kept", {31'd0, overflow}, 32'd1);

    // Idle timeout with 2 codes buffered
    send(2'b10);
    send(2'b01);
`ifdef DCT_PACKER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) step();
    check("tmo_before", {31'd0, frm_valid}, 32'd0);
    step();
    check_frame("tmo_frame", 1'b1, 30'h00000009, 4'd2);
    step();
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (frm_valid) seen++;
    end
    check("no_timeout", seen, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_frame("no_tmo_flush", 1'b1, 30'h00000009, 4'd2);
    step();
`endif
    check("tmo_drop", {31'd0, frm_valid}, 32'd0);

    // Asynchronous reset mid-cycle with a held frame and a partial frame
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b01);
    for (int i = 0; i < 7; i++) send(2'b11);
    check("pre_reset_valid", {31'd0, frm_valid}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_frame("async_reset", 1'b0, 30'd0, 4'd0);
    check("async_reset_ovf", {31'd0, overflow}, 32'd0);
    step();
    reset     = 1'b0;
    frm_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (frm_valid) seen++;
    end
    check("post_reset_quiet", seen, 32'd0);
    for (int i = 0; i < 15; i++) send(2'b10);
    step();
    check_frame("post_reset_full", 1'b1, 30'h2AAAAAAA, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
